// File: rtl/rv32_load_ctrl.sv
// RV32I load-unit controller: decodes LB/LH/LW/LBU/LHU, checks alignment,
// runs one request/grant/response read on the data port and extends the result.
module rv32_load_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_rs1,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_we,
    output logic [4:0]  out_rd,
    output logic [31:0] out_data,
    output logic [1:0]  out_exc,
    output logic [31:0] out_addr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [1:0] EXC_NONE  = 2'b00;
    localparam logic [1:0] EXC_MISAL = 2'b01;
    localparam logic [1:0] EXC_ILL   = 2'b10;
    localparam logic [1:0] EXC_BUS   = 2'b11;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    state_t            state_q, state_d;
    logic [31:0]       ea_q, ea_d;
    logic [31:0]       data_q, data_d;
    logic [2:0]        f3_q, f3_d;
    logic [4:0]        rd_q, rd_d;
    logic [1:0]        exc_q, exc_d;
    logic [3:0]        be_q, be_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [31:0]       eaIn;
    logic [2:0]        f3In;
    logic              illegalIn;
    logic              misalignedIn;
    logic [3:0]        beIn;
    logic [31:0]       lane;
    logic [31:0]       extracted;
    logic              unused_rs1_idx;

    assign unused_rs1_idx = ^in_instr[19:15];

    assign eaIn = in_rs1 + {{20{in_instr[31]}}, in_instr[31:20]};
    assign f3In = in_instr[14:12];

    always_comb begin
        illegalIn    = (in_instr[6:0] != OPC_LOAD) ||
                       (f3In == 3'b011) || (f3In == 3'b110) || (f3In == 3'b111);
        misalignedIn = ((f3In[1:0] == 2'b01) && eaIn[0]) ||
                       ((f3In[1:0] == 2'b10) && (eaIn[1:0] != 2'b00));
        case (f3In[1:0])
            2'b00:   beIn = 4'b0001 << eaIn[1:0];
            2'b01:   beIn = 4'b0011 << eaIn[1:0];
            default: beIn = 4'b1111;
        endcase
    end

    // The addressed byte/half is shifted down to bit 0 before extension.
    assign lane = mem_rdata >> {ea_q[1:0], 3'b000};

    always_comb begin
        case (f3_q)
            3'b000:  extracted = {{24{lane[7]}}, lane[7:0]};
            3'b100:  extracted = {24'h000000, lane[7:0]};
            3'b001:  extracted = {{16{lane[15]}}, lane[15:0]};
            3'b101:  extracted = {16'h0000, lane[15:0]};
            default: extracted = lane;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ea_q    <= '0;
            data_q  <= '0;
            f3_q    <= '0;
            rd_q    <= '0;
            exc_q   <= EXC_NONE;
            be_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ea_q    <= ea_d;
            data_q  <= data_d;
            f3_q    <= f3_d;
            rd_q    <= rd_d;
            exc_q   <= exc_d;
            be_q    <= be_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ea_d    = ea_q;
        data_d  = data_q;
        f3_d    = f3_q;
        rd_d    = rd_q;
        exc_d   = exc_q;
        be_d    = be_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    ea_d   = eaIn;
                    f3_d   = f3In;
                    rd_d   = in_instr[11:7];
                    data_d = '0;
                    cnt_d  = '0;
                    if (illegalIn) begin
                        exc_d   = EXC_ILL;
                        be_d    = '0;
                        state_d = S_RESP;
                    end else if (misalignedIn) begin
                        exc_d   = EXC_MISAL;
                        be_d    = '0;
                        state_d = S_RESP;
                    end else begin
                        exc_d   = EXC_NONE;
                        be_d    = beIn;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // cnt_d counts WAIT cycles including the current one.
                cnt_d = cnt_q + 1'b1;
                if (mem_rvalid) begin
                    state_d = S_RESP;
                    if (mem_err) begin
                        exc_d  = EXC_BUS;
                        data_d = '0;
                    end else begin
                        data_d = extracted;
                    end
                end else if (cnt_d == TIMEOUT_CNT) begin
                    exc_d   = EXC_BUS;
                    data_d  = '0;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign mem_req   = (state_q == S_REQ);
    assign mem_addr  = {ea_q[31:2], 2'b00};
    assign mem_be    = be_q;
    assign out_valid = (state_q == S_RESP);
    assign out_we    = out_valid && (exc_q == EXC_NONE) && (rd_q != 5'd0);
    assign out_rd    = rd_q;
    assign out_data  = data_q;
    assign out_exc   = exc_q;
    assign out_addr  = ea_q;

endmodule

// File: doc/rv32_load_ctrl.md
Name: rv32_load_ctrl

Overview:
- Multicycle load-unit controller for the RV32I load group: LB, LH, LW, LBU, LHU (opcode 0000011).
- Accepts one decoded load instruction plus its rs1 value and computes the effective address.
- Checks alignment, sequences a request/grant/response transaction on the data-memory port, then extracts and extends the loaded data.
- Sits between the issue stage and the register-file writeback port; one load in flight at a time.

Parameters:
- TIMEOUT, 255: maximum cycles in WAIT without mem_rvalid before a bus-error response.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  controller can accept; high only in IDLE.
- in_instr  in  32  raw instruction word.
- in_rs1  in  32  rs1 operand value.
- mem_req  out  1  memory read request.
- mem_addr  out  32  word-aligned address, {ea[31:2],2'b00}.
- mem_be  out  4  byte enables for the access.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data, little-endian word.
- mem_err  in  1  qualifies mem_rvalid as an access fault.
- out_valid  out  1  result available.
- out_ready  in  1  writeback consumes result.
- out_we  out  1  register write enable; 0 for rd=x0 or any exception.
- out_rd  out  5  destination register in_instr[11:7].
- out_data  out  32  extended load data; 0 on exception.
- out_exc  out  2  00 none, 01 misaligned, 10 illegal, 11 bus error.
- out_addr  out  32  effective address (trap value).

Behaviour:
- Reset: state IDLE, in_ready=1. mem_req, out_valid, out_we=0. mem_addr, mem_be, out_data, out_addr=0. out_rd=0, out_exc=00, counter=0. Reset mid-transaction abandons the access; subsequent mem_rvalid is ignored.
- Effective address (ea) = in_rs1 + sign_extend(in_instr[31:20]), modulo 2^32 (wrap allowed). Latched with funct3 and rd on acceptance (in_valid && in_ready).
- Decode at acceptance:
  - opcode != 0000011, or funct3 in {011,110,111}: exc=10 and go to RESP.
  - LH/LHU with ea[0]=1, or LW with ea[1:0]!=0: exc=01 and go to RESP.
  - Any exception path issues no memory access.
- Otherwise go to REQ.
- Byte enables: byte access 0001<<ea[1:0]; half access 0011<<ea[1:0]; word access 1111.
- FSM states:
  - IDLE: in_ready=1.
  - REQ: mem_req=1 with addr/be stable until mem_gnt; on gnt, clear counter and go to WAIT. Zero-wait gnt is allowed: one cycle in REQ.
  - WAIT: counter increments each cycle. On mem_rvalid, capture data and go to RESP; exc=11 if mem_err. If counter==TIMEOUT with no rvalid, exc=11 and go to RESP. rvalid takes priority over timeout in the same cycle.
  - RESP: out_valid=1 with all outputs stable until out_ready; then return to IDLE. No back-to-back acceptance in the same cycle as the RESP handshake.
- Extraction: lane = mem_rdata >> (8*ea[1:0]).
  - LB: sign-extend lane[7:0]. LBU: zero-extend lane[7:0].
  - LH: sign-extend lane[15:0]. LHU: zero-extend lane[15:0].
  - LW: full word.
- Latency for a valid load with zero-wait memory: accept at cycle 0, mem_req in cycle 1 (gnt), rvalid in cycle 2, out_valid in cycle 3.
- mem_gnt or mem_rvalid outside REQ/WAIT is ignored.

Test Plan:
- LW, rs1=0x1000, imm=+4, gnt and rvalid immediate, rdata=0xDEADBEEF -> mem_addr=0x1004, be=1111, out_valid at cycle 3, out_data=0xDEADBEEF, out_we=1.
- LB/LBU, ea=0x2003, rdata=0x80FF_FF12 -> be=1000; LB out_data=0xFFFFFF80, LBU out_data=0x00000080.
- LH, ea=0x3001 -> no mem_req, out_exc=01, out_addr=0x3001, out_we=0, out_data=0. Same for LW at ea=0x3002.
- funct3=011 with load opcode, and an opcode 0110111 (LUI) input -> out_exc=10, no memory access.
- gnt delayed 3 cycles (mem_req and mem_addr held stable); then rvalid never arrives -> exc=11 after exactly TIMEOUT WAIT cycles. Separately, rvalid with mem_err=1 -> exc=11.
- out_ready held low 5 cycles in RESP -> outputs stable, in_ready=0. rd=x0 LW -> out_we=0. Async rst asserted in WAIT -> IDLE immediately; a following stray rvalid produces no output.
